// File: rtl/bsg_bus_initiator.sv
// Register-bus initiator: queues controller read/write commands in a small FIFO and runs them
// one at a time on a valid/ready bus, returning one response (data or timeout) per command.
module bsg_bus_initiator #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  SYS_CLK,
    input  logic                  rst,
    // Controller command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [DATA_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // Register bus
    output logic                  bus_valid,
    output logic                  bus_write,
    output logic [DATA_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ready,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    // Response side
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  busy
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StGap
    } state_e;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic                  fifo_write_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;
    logic fifo_empty;

    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = (count_q != FULL_COUNT);
    assign push       = cmd_valid & cmd_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge SYS_CLK or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge SYS_CLK) begin
        if (push) begin
            fifo_write_q[wr_ptr_q] <= cmd_write;
            fifo_addr_q[wr_ptr_q]  <= cmd_addr;
            fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    state_e state_q, state_d;

    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  bus_valid_q, bus_valid_d;
    logic                  bus_write_q, bus_write_d;
    logic [DATA_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        bus_valid_d = bus_valid_q;
        bus_write_d = bus_write_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        pop         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    bus_valid_d = 1'b1;
                    bus_write_d = fifo_write_q[rd_ptr_q];
                    bus_addr_d  = fifo_addr_q[rd_ptr_q];
                    bus_wdata_d = fifo_wdata_q[rd_ptr_q];
                    wait_d      = '0;
                    state_d     = StReq;
                end
            end
            StReq: begin
                if (bus_ready) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = bus_write_q ? '0 : bus_rdata;
                    bus_valid_d = 1'b0;
                    state_d     = StGap;
                end else if (wait_q == WAIT_LAST) begin
                    // bus_valid has now been high for TIMEOUT cycles
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                    bus_valid_d = 1'b0;
                    state_d     = StGap;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            wait_q      <= '0;
            bus_valid_q <= 1'b0;
            bus_write_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            bus_valid_q <= bus_valid_d;
            bus_write_q <= bus_write_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign bus_valid = bus_valid_q;
    assign bus_write = bus_write_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign busy      = !fifo_empty || (state_q != StIdle);

endmodule
